// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the sequential signed divider.
//   DIV_BITS : default divisor/quotient/remainder width (dividend is 2*DIV_BITS)
//   state_t  : divider control states
package div_pkg;

  localparam int DIV_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: request/result bundle of the sequential divider.
//   start      : request, sampled by the divider only while idle
//   N          : signed dividend, 2*bits wide
//   D          : signed divisor, bits wide
//   Q, R       : signed quotient / remainder
//   busy       : operation in progress
//   done       : one-cycle result-valid pulse
//   dbz, ovf   : divide-by-zero / quotient-overflow flags, valid with done
// Modports: master drives requests, slave is the divider.
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int bits = DIV_BITS
) ();

  logic                  start;
  logic [2*bits-1:0]     N;
  logic [bits-1:0]       D;
  logic [bits-1:0]       Q;
  logic [bits-1:0]       R;
  logic                  busy;
  logic                  done;
  logic                  dbz;
  logic                  ovf;

  modport master (
    output start, N, D,
    input  Q, R, busy, done, dbz, ovf
  );

  modport slave (
    input  start, N, D,
    output Q, R, busy, done, dbz, ovf
  );

endinterface

// File: rtl/div_sign_fix.sv
// div_sign_fix: combinational sign handling around the unsigned divider core.
//   n_in, d_in   : raw signed operands -> n_mag, d_mag magnitudes, d_zero flag
//   n_neg, d_neg : operand signs of the running operation
//   q_mag, r_mag : unsigned quotient / remainder from the iteration
//   hi_ovf       : quotient magnitude already known to need more than bits bits
//   dbz          : divisor of the running operation was zero
//   q, r, ovf    : signed results (zeroed on overflow or divide-by-zero)
module div_sign_fix
  import div_pkg::*;
#(
  parameter int bits = DIV_BITS
) (
  input  logic [2*bits-1:0] n_in,
  input  logic [bits-1:0]   d_in,
  output logic [2*bits-1:0] n_mag,
  output logic [bits-1:0]   d_mag,
  output logic              d_zero,
  input  logic              n_neg,
  input  logic              d_neg,
  input  logic [bits-1:0]   q_mag,
  input  logic [bits-1:0]   r_mag,
  input  logic              hi_ovf,
  input  logic              dbz,
  output logic [bits-1:0]   q,
  output logic [bits-1:0]   r,
  output logic              ovf
);

  logic q_neg;
  logic range_ovf;

  always_comb begin
    // Two's complement negation of the most negative value yields its
    // magnitude correctly when read back as unsigned.
    n_mag  = n_in[2*bits-1] ? -n_in : n_in;
    d_mag  = d_in[bits-1] ? -d_in : d_in;
    d_zero = (d_in == '0);

    q_neg = n_neg ^ d_neg;
    // A negative quotient may reach magnitude 2^(bits-1); a positive one
    // must stay strictly below it.
    if (q_neg) begin
      range_ovf = q_mag[bits-1] & (|q_mag[bits-2:0]);
    end else begin
      range_ovf = q_mag[bits-1];
    end
    ovf = !dbz && (hi_ovf || range_ovf);

    q = '0;
    r = '0;
    if (!dbz && !ovf) begin
      q = q_neg ? -q_mag : q_mag;
      // Remainder carries the dividend's sign (truncating division).
      r = n_neg ? -r_mag : r_mag;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed divider, 2*bits / bits -> bits quotient and
// remainder, truncating toward zero. One quotient bit per cycle (restoring
// shift/subtract on magnitudes), then one cycle of sign correction.
//   clk   : clock, all state on the rising edge
//   reset : asynchronous active-low reset
//   bus   : seq_divider_if.slave (start, N, D in; Q, R, busy, done, dbz, ovf out)
// Configuration macro DIVIDER_DBZ_FAST_EN: when defined, a zero divisor skips
// the iteration and reports done one cycle after the request is accepted.
module seq_divider
  import div_pkg::*;
#(
  parameter int bits = DIV_BITS
) (
  input  logic        clk,
  input  logic        reset,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(bits + 1);

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg;
  logic [bits-1:0]   rem_reg;
  logic [bits-1:0]   quo_reg;
  logic [bits-1:0]   dm_reg;
  logic              n_neg_reg, d_neg_reg;
  logic              hi_ovf_reg, dzero_reg;
  logic [bits-1:0]   res_q_reg, res_r_reg;
  logic              res_dbz_reg, res_ovf_reg;
  logic [bits-1:0]   q_reg, r_reg;
  logic              dbz_reg, ovf_reg, done_reg;

  logic [2*bits-1:0] n_mag;
  logic [bits-1:0]   d_mag;
  logic              d_zero;
  logic [bits-1:0]   fix_q, fix_r;
  logic              fix_ovf;

  logic [bits:0]     trial;
  logic              take;
  logic [bits-1:0]   rem_next;

  // Magnitudes come from the live inputs (only used on the accepting edge);
  // sign correction works on the latched operation.
  div_sign_fix #(.bits(bits)) u_sign_fix (
    .n_in   (bus.N),
    .d_in   (bus.D),
    .n_mag  (n_mag),
    .d_mag  (d_mag),
    .d_zero (d_zero),
    .n_neg  (n_neg_reg),
    .d_neg  (d_neg_reg),
    .q_mag  (quo_reg),
    .r_mag  (rem_reg),
    .hi_ovf (hi_ovf_reg),
    .dbz    (dzero_reg),
    .q      (fix_q),
    .r      (fix_r),
    .ovf    (fix_ovf)
  );

  // Restoring step: quo_reg starts as the low dividend half and is shifted
  // out MSB first while quotient bits shift in at the LSB. The partial
  // remainder stays below the divisor, so the true difference fits in bits.
  always_comb begin
    trial    = {rem_reg, quo_reg[bits-1]};
    take     = (trial >= {1'b0, dm_reg});
    rem_next = take ? (trial[bits-1:0] - dm_reg) : trial[bits-1:0];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
`ifdef DIVIDER_DBZ_FAST_EN
          state_next = d_zero ? DONE : CALC;
`else
          state_next = CALC;
`endif
        end
      end
      CALC: begin
        if (cnt_reg == CW'(bits - 1)) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      dm_reg      <= '0;
      n_neg_reg   <= 1'b0;
      d_neg_reg   <= 1'b0;
      hi_ovf_reg  <= 1'b0;
      dzero_reg   <= 1'b0;
      res_q_reg   <= '0;
      res_r_reg   <= '0;
      res_dbz_reg <= 1'b0;
      res_ovf_reg <= 1'b0;
      q_reg       <= '0;
      r_reg       <= '0;
      dbz_reg     <= 1'b0;
      ovf_reg     <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            n_neg_reg  <= bus.N[2*bits-1];
            d_neg_reg  <= bus.D[bits-1];
            rem_reg    <= n_mag[2*bits-1:bits];
            quo_reg    <= n_mag[bits-1:0];
            dm_reg     <= d_mag;
            // High half >= divisor means the quotient needs > bits bits.
            hi_ovf_reg <= (n_mag[2*bits-1:bits] >= d_mag);
            dzero_reg  <= d_zero;
            cnt_reg    <= '0;
            // Preload the divide-by-zero result for the shortcut path.
            res_q_reg   <= '0;
            res_r_reg   <= '0;
            res_dbz_reg <= d_zero;
            res_ovf_reg <= 1'b0;
          end
        end
        CALC: begin
          rem_reg <= rem_next;
          quo_reg <= {quo_reg[bits-2:0], take};
          cnt_reg <= cnt_reg + 1'b1;
        end
        FIX: begin
          res_q_reg   <= fix_q;
          res_r_reg   <= fix_r;
          res_dbz_reg <= dzero_reg;
          res_ovf_reg <= fix_ovf;
        end
        DONE: begin
          // Outputs change only here, together with the done pulse.
          q_reg    <= res_q_reg;
          r_reg    <= res_r_reg;
          dbz_reg  <= res_dbz_reg;
          ovf_reg  <= res_ovf_reg;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.Q    = q_reg;
  assign bus.R    = r_reg;
  assign bus.dbz  = dbz_reg;
  assign bus.ovf  = ovf_reg;
  assign bus.done = done_reg;
  assign bus.busy = (state_reg != IDLE);

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table-driven bench for seq_divider (bits = 8) with a
// scoreboard queue: expectations are pushed when a request is driven and
// popped by a monitor when done pulses. Hand-written sequences cover the
// ignored-start and reset-abort cases.
module tb_seq_divider;

  logic clk;
  logic reset;

  seq_divider_if #(.bits(8)) bus ();

  seq_divider #(.bits(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] n;
    logic [7:0]  d;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dbz;
    logic        ovf;
  } vec_t;

  typedef struct {
    vec_t v;
    int   tag;
    int   accept;
    int   lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   edge_cnt = 0;
  int   done_seen = 0;
  vec_t vecs[18];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      edge_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && bus.done === 1'b1) begin
        done_seen++;
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL spurious done at edge %0d: got done=1, expected 0", edge_cnt);
        end else begin
          e = sb.pop_front();
          check($sformatf("op%0d Q", e.tag), 32'(bus.Q), 32'(e.v.q));
          check($sformatf("op%0d R", e.tag), 32'(bus.R), 32'(e.v.r));
          check($sformatf("op%0d dbz", e.tag), 32'(bus.dbz), 32'(e.v.dbz));
          check($sformatf("op%0d ovf", e.tag), 32'(bus.ovf), 32'(e.v.ovf));
          check($sformatf("op%0d latency", e.tag), 32'(edge_cnt - e.accept), 32'(e.lat));
          $display("op%0d N=%h D=%h -> Q=%h R=%h dbz=%b ovf=%b latency=%0d",
                   e.tag, e.v.n, e.v.d, bus.Q, bus.R, bus.dbz, bus.ovf, edge_cnt - e.accept);
        end
      end
    end
  end

  task automatic issue_op(input vec_t v, input int tag);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (bus.busy !== 1'b0) begin
      n_checks++;
      $display("FAIL op%0d idle wait: got busy=%b, expected 0", tag, bus.busy);
      return;
    end
    bus.start = 1'b1;
    bus.N     = v.n;
    bus.D     = v.d;
    e.v      = v;
    e.tag    = tag;
    e.accept = edge_cnt + 1;
`ifdef DIVIDER_DBZ_FAST_EN
    e.lat    = (v.d == 8'h00) ? 1 : 10;
`else
    e.lat    = 10;
`endif
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    check($sformatf("op%0d busy after accept", tag), 32'(bus.busy), 32'(1));
  endtask

  task automatic wait_done(input int tag);
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 40) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL op%0d timeout: got no done, expected one within 40 cycles", tag);
      sb.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, 32'(bus.busy), 32'(0));
    check({tag, " done"}, 32'(bus.done), 32'(0));
    check({tag, " dbz"},  32'(bus.dbz),  32'(0));
    check({tag, " ovf"},  32'(bus.ovf),  32'(0));
    check({tag, " Q"},    32'(bus.Q),    32'(0));
    check({tag, " R"},    32'(bus.R),    32'(0));
  endtask

  initial begin
    vec_t v;
    int   done_before;

    //          N        D      Q      R     dbz   ovf
    vecs[0]  = '{16'h3D84, 8'h84, 8'h81, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0};
    vecs[2]  = '{16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0};
    vecs[3]  = '{16'h4000, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[4]  = '{16'hFF80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{16'h1234, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{16'h007F, 8'h01, 8'h7F, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{16'h0080, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[8]  = '{16'h0080, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{16'h8000, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{16'hFF81, 8'h80, 8'h00, 8'h81, 1'b0, 1'b0};
    vecs[11] = '{16'h03E8, 8'hF9, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[12] = '{16'h0000, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[13] = '{16'hC000, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[14] = '{16'h4000, 8'h80, 8'h80, 8'h00, 1'b0, 1'b0};
    vecs[15] = '{16'h7FFF, 8'h7F, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[16] = '{16'hFC18, 8'h0D, 8'hB4, 8'hF4, 1'b0, 1'b0};
    vecs[17] = '{16'h8000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};

    reset     = 1'b0;
    bus.start = 1'b0;
    bus.N     = '0;
    bus.D     = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;

    // Each op is issued in the cycle right after the previous done.
    for (int i = 0; i < 18; i++) begin
      issue_op(vecs[i], i);
      wait_done(i);
    end

    // Second start at cycle 3 with new operands must be ignored.
    done_before = done_seen;
    v = '{16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0};
    issue_op(v, 100);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.N     = 16'hFF9C;
    bus.D     = 8'h03;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(100);
    repeat (15) @(negedge clk);
    check("ignored start done count", 32'(done_seen - done_before), 32'(1));
    check("hold Q", 32'(bus.Q), 32'(8'h0E));
    check("hold R", 32'(bus.R), 32'(8'h02));
    $display("seq100 ignored start: done count=%0d Q=%h R=%h", done_seen - done_before, bus.Q, bus.R);

    // Reset in the fifth CALC cycle aborts without a done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    bus.N     = 16'h3D84;
    bus.D     = 8'h84;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid-op busy", 32'(bus.busy), 32'(1));
    reset = 1'b0;
    #1;
    check_all_zero("abort");
    done_before = done_seen;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (14) @(negedge clk);
    check("abort no done", 32'(done_seen - done_before), 32'(0));
    $display("seq200 reset abort: done count after abort=%0d", done_seen - done_before);

    v = '{16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0};
    issue_op(v, 201);
    wait_done(201);
    v = '{16'h3D84, 8'h84, 8'h81, 8'h00, 1'b0, 1'b0};
    issue_op(v, 202);
    wait_done(202);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter: bits, default 8, divisor/quotient/remainder width; dividend width is 2*bits.
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  in  1  request; sampled only in IDLE.
REQ-005 SHALL have port: N  in  2*bits  signed dividend.
REQ-006 SHALL have port: D  in  bits  signed divisor.
REQ-007 SHALL have port: Q  out  bits  signed quotient.
REQ-008 SHALL have port: R  out  bits  signed remainder.
REQ-009 SHALL have port: busy  out  1  high from accepted start until done.
REQ-010 SHALL have port: done  out  1  one-cycle result-valid pulse.
REQ-011 SHALL have ports: dbz, ovf  out  1 each  divide-by-zero and quotient-overflow flags, valid with done.

Function
REQ-012 SHALL implement the inverse of the team multiplier: Q = N/D truncated toward zero, R = N - Q*D, R sign equal to N sign or R = 0.
REQ-013 SHALL use FSM states IDLE, CALC, FIX, DONE: IDLE->CALC on start; CALC for exactly bits cycles, one quotient bit per cycle; CALC->FIX; FIX->DONE; DONE->IDLE unconditionally.
REQ-014 SHALL latch N and D on the accepting edge; later input changes do not affect the running operation.
REQ-015 SHALL assert done for exactly one cycle, bits+2 cycles after the accepting edge (10 for bits=8).
REQ-016 SHALL hold Q, R, dbz, ovf stable from done until the next accepted start.
REQ-017 SHALL ignore start while busy; no queuing.
REQ-018 SHALL accept start in the cycle after done (back-to-back operation).
REQ-019 SHALL work on magnitudes: |N| and |D| in CALC, sign correction of Q and R in FIX.
REQ-020 SHALL set ovf=1 when the true quotient lies outside [-2^(bits-1), 2^(bits-1)-1]; Q and R are then 0.
REQ-021 SHALL set dbz=1, ovf=0, Q=0, R=0 when D=0.
REQ-022 SHALL give Q = -2^(bits-1) with ovf=0 when that is the exact truncated quotient.

Reset
REQ-023 SHALL, with reset low, force IDLE and busy=0, done=0, dbz=0, ovf=0, Q=0, R=0, regardless of clk.
REQ-024 SHALL abort an in-flight operation on reset with no done pulse, and resume in IDLE on the first edge after release.

Configuration
REQ-025 SHALL honour macro DIVIDER_DBZ_FAST_EN: defined -> D=0 goes IDLE->DONE directly, done one cycle after accept; undefined -> D=0 takes full bits+2 latency. Flags and values per REQ-021 in both cases.

Structure
REQ-026 SHALL place the FSM state enum and default width constant in shared package div_pkg.
REQ-027 SHALL put magnitude conversion and final sign correction in one combinational sub-module div_sign_fix; the shift/subtract datapath and FSM stay in seq_divider.

Verification (bits=8)
REQ-028 SHALL check N=16'h3D84, D=8'h84 (multiplier result for 0x81*0x84) -> Q=8'h81, R=8'h00, done exactly 10 cycles after accept.
REQ-029 SHALL check N=16'h0064, D=8'h07 -> Q=8'h0E, R=8'h02; N=16'hFF9C, D=8'h07 -> Q=8'hF2, R=8'hFE.
REQ-030 SHALL check overflow boundaries: N=16'h4000, D=8'h01 -> ovf=1, Q=0, R=0; N=16'hFF80, D=8'h01 -> Q=8'h80, ovf=0.
REQ-031 SHALL check D=8'h00, N=16'h1234 -> dbz=1, Q=0, R=0; done after 1 cycle with DIVIDER_DBZ_FAST_EN, after 10 without.
REQ-032 SHALL check start pulsed at cycle 3 of a running operation, with N/D changed -> ignored, first result unchanged, single done.
REQ-033 SHALL check reset asserted at cycle 5 of CALC -> all outputs 0 immediately, no done; a new operation after release completes correctly.
